// File: rtl/mips_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_queue
// Description : Instruction fetch unit with a show-ahead instruction queue.
//               Issues one outstanding request at a time to instruction
//               memory and buffers returned words with their fetch PCs.
//               A redirect flushes the queue and restarts fetch. If a fetch
//               is still outstanding when the redirect arrives, its late
//               response is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    // The queue uses natural pointer wrap, so the depth must be a power of two.
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mips_fetch_queue: DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_pc_next;
    logic [31:0]     r_req_addr;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [31:0]     r_mem_instr [DEPTH];
    logic [31:0]     r_mem_pc    [DEPTH];
    logic            w_push;
    logic            w_pop;
    logic            w_new_req;
    logic [31:0]     w_redirect_aligned;
    logic            w_unused;

    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign w_unused           = ^redirect_pc[1:0];

    // Next-state, next fetch PC and queue push/pop decisions; redirect wins.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_fetch_pc;
        w_pop        = instr_valid && instr_ready && !redirect;
        w_push       = (r_state == S_WAIT) && imem_ack && !redirect;
        w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

        case (r_state)
            S_IDLE: begin
                // Acks arriving here belong to an abandoned request; ignore them.
                if (redirect) begin
                    w_pc_next    = w_redirect_aligned;
                    w_state_next = S_WAIT;
                end else if (r_count < C_DEPTH) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_pc_next    = w_redirect_aligned;
                    w_state_next = imem_ack ? S_WAIT : S_DROP;
                end else if (imem_ack) begin
                    w_pc_next    = r_fetch_pc + 32'd4;
                    w_state_next = (w_count_next < C_DEPTH) ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_pc_next = w_redirect_aligned;
                end else if (imem_ack) begin
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A fresh request starts on entry to WAIT from IDLE, or whenever the
        // current request completes (ack) and WAIT follows.
        w_new_req = (w_state_next == S_WAIT) && ((r_state == S_IDLE) || imem_ack);
    end

    // Fetch FSM, fetch PC and the address of the outstanding request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_pc_next;
            if (w_new_req) begin
                r_req_addr <= w_pc_next;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_fetch_pc;
        end
    end

    // The FSM only requests when there is room, so a push can never hit a full queue.
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_no_push_when_full: assert (!(w_push && (r_count == C_DEPTH)));
        end
    end

    assign imem_req    = (r_state != S_IDLE);
    assign imem_addr   = r_req_addr;
    assign instr_valid = (r_count != '0);
    assign instr       = r_mem_instr[r_rptr];
    assign instr_pc    = r_mem_pc[r_rptr];
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_queue
// Description : Directed bench for mips_fetch_queue. Stimulus pushes the
//               expected {pc, instr} pairs into a scoreboard queue, and a
//               monitor pops and compares them on every consumed head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    bit          auto_en = 1'b0;
    int          age     = 0;
    int          n;

    mips_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock edge; in auto mode the memory acks the second cycle
    // of each request with data 0xC0DE_xxxx where xxxx = address[15:0].
    task automatic tick();
        @(posedge clock);
        #1;
        redirect = 1'b0;
        imem_ack = 1'b0;
        if (auto_en) begin
            if (imem_req) age++;
            else          age = 0;
            if (imem_req && age >= 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hC0DE_0000 | {16'h0000, imem_addr[15:0]};
                age        = 0;
            end
        end
    endtask

    // Monitor: every head the core actually consumes must match the scoreboard.
    always @(negedge clock) begin
        if (!reset && instr_valid && instr_ready && !redirect) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h expected no entry", instr_pc, instr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({instr_pc, instr} !== mon_e) begin
                    bad++;
                    $display("FAIL pop_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);

        // Fill from reset with one-cycle-late acks and no consumption
        exp_q.push_back({32'h0000_0000, 32'hC0DE_0000});
        exp_q.push_back({32'h0000_0004, 32'hC0DE_0004});
        exp_q.push_back({32'h0000_0008, 32'hC0DE_0008});
        exp_q.push_back({32'h0000_000C, 32'hC0DE_000C});
        auto_en = 1'b1;
        reset   = 1'b0;
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("lat_valid", instr_valid, 1);
        chk("lat_count", count, 1);
        chk("lat_instr_pc", instr_pc, 32'h0);
        chk("lat_next_addr", imem_addr, 32'h4);
        n = 0;
        while (!(count == 3'd4 && !imem_req) && n < 40) begin tick(); n++; end
        chk("fill_timeout", n < 40, 1);
        chk("full_count", count, 4);
        chk("full_req", imem_req, 0);
        chk("full_instr_pc", instr_pc, 32'h0);
        tick(); tick();
        chk("full_stays_idle", imem_req, 0);

        // One pop from full: head advances, fetch resumes at 16
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pop_instr_pc", instr_pc, 32'h4);
        chk("pop_count", count, 3);
        exp_q.push_back({32'h0000_0010, 32'hC0DE_0010});
        tick();
        chk("refill_req", imem_req, 1);
        chk("refill_addr", imem_addr, 32'h10);
        n = 0;
        while (!(count == 3'd4 && !imem_req) && n < 40) begin tick(); n++; end
        chk("refill_timeout", n < 40, 1);
        chk("refill_count", count, 4);

        // Drain with memory silent; fetch parks in WAIT at 20
        auto_en     = 1'b0;
        age         = 0;
        instr_ready = 1'b1;
        n = 0;
        while (count != 3'd0 && n < 40) begin tick(); n++; end
        instr_ready = 1'b0;
        chk("drain_timeout", n < 40, 1);
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 32'h14);

        // Reset mid-request, stale ack in IDLE, then the real fetch
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_req", imem_req, 0);
        chk("rst_mid_count", count, 0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("idle_ack_count", count, 0);
        chk("idle_ack_req", imem_req, 1);
        chk("idle_ack_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0000;
        exp_q.push_back({32'h0000_0000, 32'hC0DE_0000});
        tick();
        chk("rst_fetch_count", count, 1);
        chk("rst_fetch_pc", instr_pc, 32'h0);
        chk("rst_fetch_instr", instr, 32'hC0DE_0000);
        tick();
        chk("rst_no_extra", count, 1);

        // Redirect while waiting at 8 with no ack: DROP, stale ack discarded
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0004;
        exp_q.push_back({32'h0000_0004, 32'hC0DE_0004});
        tick();
        chk("pre_redir_count", count, 2);
        chk("pre_redir_addr", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_q.delete();
        tick();
        chk("drop_count", count, 0);
        chk("drop_valid", instr_valid, 0);
        chk("drop_req", imem_req, 1);
        chk("drop_addr_stable", imem_addr, 32'h8);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0008;
        tick();
        chk("stale_count", count, 0);
        chk("new_req_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0100;
        exp_q.push_back({32'h0000_0100, 32'hC0DE_0100});
        tick();
        chk("redir_count", count, 1);
        chk("redir_instr_pc", instr_pc, 32'h100);

        // Redirect, ack and pop together: queue empties, ack data lost
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hC0DE_0104;
        instr_ready = 1'b1;
        exp_q.delete();
        tick();
        instr_ready = 1'b0;
        chk("rap_count", count, 0);
        chk("rap_valid", instr_valid, 0);
        chk("rap_addr", imem_addr, 32'h40);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0040;
        exp_q.push_back({32'h0000_0040, 32'hC0DE_0040});
        tick();
        chk("rap_fetch_pc", instr_pc, 32'h40);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("rap_drained", count, 0);

        // PC wrap at the top of the address space (unaligned target)
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_FFFC;
        exp_q.push_back({32'hFFFF_FFFC, 32'hC0DE_FFFC});
        tick();
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem_addr, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // Redirect again while in DROP: stay in DROP, then fetch newest target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0304;
        tick();
        chk("drop2_req", imem_req, 1);
        chk("drop2_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0000;
        tick();
        chk("drop2_count", count, 0);
        chk("drop2_new_addr", imem_addr, 32'h304);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC0DE_0304;
        exp_q.push_back({32'h0000_0304, 32'hC0DE_0304});
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
